mem_stage: RTL and testbench

Pipeline MEM stage of the RV32I core, between the EX/MEM register and the writeback stage. Issues loads and stores to the data cache, holds the pipeline until the cache responds, and performs store lane steering and load byte/halfword extraction with sign or zero extension. Owns the MEM/WB pipeline register that feeds writeback. Extended load data goes out as a full word, so writeback always takes the plain word path.

---
 rtl/mem_stage_pkg.sv | 56 +++++
 rtl/mem_stage_align.sv | 46 ++++
 rtl/mem_stage.sv | 143 ++++++++++++++
 tb/tb_mem_stage.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types for the RV32I MEM stage: memory/writeback control words,
// load/store funct3 encodings and the MEM request state machine states.
package mem_stage_pkg;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } store_funct3_t;

  typedef enum logic [3:0] {
    RF_ALU_OUT  = 4'd0,
    RF_BR_EN    = 4'd1,
    RF_U_IMM    = 4'd2,
    RF_LW       = 4'd3,
    RF_PC_PLUS4 = 4'd4,
    RF_LB       = 4'd5,
    RF_LBU      = 4'd6,
    RF_LH       = 4'd7,
    RF_LHU      = 4'd8
  } regfilemux_sel_t;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic [2:0] funct3;
  } cw_mem;

  typedef struct packed {
    regfilemux_sel_t regfilemux_sel;
    logic            ld_reg;
    logic [4:0]      rd_sel;
  } cw_writeback;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  // Load data leaves MEM already extended, so writeback only needs the word path.
  function automatic regfilemux_sel_t wb_sel_fixup(input regfilemux_sel_t sel);
    case (sel)
      RF_LB, RF_LBU, RF_LH, RF_LHU: return RF_LW;
      default:                      return sel;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_align.sv
// Store lane steering and load lane extraction/extension for the MEM stage.
module mem_stage_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_sel,
  input  logic [31:0] rs2,
  input  logic [31:0] rdata,
  output logic [3:0]  wmask,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    wmask = 4'b1111;
    wdata = rs2;
    case (funct3)
      SB: begin
        wmask = 4'b0001 << byte_sel;
        wdata = rs2 << {byte_sel, 3'b000};
      end
      SH: begin
        wmask = 4'b0011 << {byte_sel[1], 1'b0};
        wdata = rs2 << {byte_sel[1], 4'b0000};
      end
      default: ;
    endcase
  end

  // Misaligned halfwords fall back to the aligned lane chosen by byte_sel[1].
  always_comb begin
    byte_lane = rdata[{byte_sel, 3'b000} +: 8];
    half_lane = byte_sel[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      LB:      load_data = {{24{byte_lane[7]}}, byte_lane};
      LH:      load_data = {{16{half_lane[15]}}, half_lane};
      LBU:     load_data = {24'd0, byte_lane};
      LHU:     load_data = {16'd0, half_lane};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32I MEM stage: data cache handshake, stall generation and the MEM/WB register.
// Optional stall cycle counter enabled by defining MEM_STALL_CNT_EN.
//
// state | meaning
// IDLE  | no request outstanding; a new memory op is issued straight from EX/MEM
// WAIT  | request issued, strobe/address/mask/data replayed from capture regs until dmem_resp
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  cw_mem       ctrl_m_MEM,
  input  cw_writeback ctrl_w_MEM,
  input  logic [31:0] alu_out_mem,
  input  logic [31:0] rs2_mem,
  input  logic        br_en_mem,
  input  logic [31:0] u_imm_mem,
  input  logic [31:0] pc_mem,
  output logic [31:0] dmem_address,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [3:0]  dmem_wmask,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic        stall_mem,
  output logic        wb_valid,
  output cw_writeback ctrl_w_WB,
  output logic [31:0] alu_out_wb,
  output logic        br_en_wb,
  output logic [31:0] u_imm_wb,
  output logic [31:0] mem_data_out_wb,
  output logic [31:0] pc_wb,
  output logic [31:0] stall_cycles
);

  mem_state_t  state;
  logic        mem_op;
  logic        rd_req;
  logic        wr_req;
  logic [31:0] addr_aligned;
  logic [3:0]  wmask;
  logic [31:0] wdata;
  logic [31:0] load_data;
  logic        req_read;
  logic        req_write;
  logic [31:0] req_addr;
  logic [3:0]  req_wmask;
  logic [31:0] req_wdata;
  logic        in_wait;

  assign mem_op       = ex_valid & (ctrl_m_MEM.mem_read | ctrl_m_MEM.mem_write);
  assign rd_req       = mem_op & ctrl_m_MEM.mem_read;
  assign wr_req       = mem_op & ~ctrl_m_MEM.mem_read & ctrl_m_MEM.mem_write;
  assign addr_aligned = {alu_out_mem[31:2], 2'b00};
  assign stall_mem    = mem_op & ~dmem_resp;
  assign in_wait      = (state == WAIT);

  mem_stage_align u_align (
    .funct3    (ctrl_m_MEM.funct3),
    .byte_sel  (alu_out_mem[1:0]),
    .rs2       (rs2_mem),
    .rdata     (dmem_rdata),
    .wmask     (wmask),
    .wdata     (wdata),
    .load_data (load_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      req_read  <= 1'b0;
      req_write <= 1'b0;
      req_addr  <= '0;
      req_wmask <= '0;
      req_wdata <= '0;
    end else begin
      case (state)
        IDLE: if (mem_op && !dmem_resp) begin
          state     <= WAIT;
          req_read  <= rd_req;
          req_write <= wr_req;
          req_addr  <= addr_aligned;
          req_wmask <= wmask;
          req_wdata <= wdata;
        end
        WAIT: if (dmem_resp) state <= IDLE;
      endcase
    end
  end

  // Strobes are gated by rst so a reset mid-request drops them without waiting for a clock.
  assign dmem_read    = rst & (in_wait ? req_read  : rd_req);
  assign dmem_write   = rst & (in_wait ? req_write : wr_req);
  assign dmem_address = in_wait ? req_addr  : addr_aligned;
  assign dmem_wmask   = in_wait ? req_wmask : wmask;
  assign dmem_wdata   = in_wait ? req_wdata : wdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid        <= 1'b0;
      ctrl_w_WB       <= '0;
      alu_out_wb      <= '0;
      br_en_wb        <= 1'b0;
      u_imm_wb        <= '0;
      mem_data_out_wb <= '0;
      pc_wb           <= '0;
    end else if (stall_mem) begin
      wb_valid        <= 1'b0;
      ctrl_w_WB       <= '0;
      alu_out_wb      <= '0;
      br_en_wb        <= 1'b0;
      u_imm_wb        <= '0;
      mem_data_out_wb <= '0;
      pc_wb           <= '0;
    end else begin
      wb_valid                 <= ex_valid;
      ctrl_w_WB.regfilemux_sel <= wb_sel_fixup(ctrl_w_MEM.regfilemux_sel);
      ctrl_w_WB.ld_reg         <= ctrl_w_MEM.ld_reg;
      ctrl_w_WB.rd_sel         <= ctrl_w_MEM.rd_sel;
      alu_out_wb               <= alu_out_mem;
      br_en_wb                 <= br_en_mem;
      u_imm_wb                 <= u_imm_mem;
      mem_data_out_wb          <= load_data;
      pc_wb                    <= pc_mem;
    end
  end

`ifdef MEM_STALL_CNT_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          stall_cnt <= '0;
    else if (stall_mem) stall_cnt <= stall_cnt + 32'd1;
  end

  assign stall_cycles = stall_cnt;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: randomized instruction stream against a
// transaction-level model, plus directed cases with literal expectations.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  cw_mem       ctrl_m_MEM;
  cw_writeback ctrl_w_MEM;
  logic [31:0] alu_out_mem, rs2_mem, u_imm_mem, pc_mem;
  logic        br_en_mem;
  logic [31:0] dmem_address, dmem_wdata, dmem_rdata;
  logic        dmem_read, dmem_write, dmem_resp;
  logic [3:0]  dmem_wmask;
  logic        stall_mem, wb_valid, br_en_wb;
  cw_writeback ctrl_w_WB;
  logic [31:0] alu_out_wb, u_imm_wb, mem_data_out_wb, pc_wb, stall_cycles;

  mem_stage dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ctrl_m_MEM(ctrl_m_MEM), .ctrl_w_MEM(ctrl_w_MEM),
    .alu_out_mem(alu_out_mem), .rs2_mem(rs2_mem), .br_en_mem(br_en_mem), .u_imm_mem(u_imm_mem),
    .pc_mem(pc_mem), .dmem_address(dmem_address), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .stall_mem(stall_mem), .wb_valid(wb_valid), .ctrl_w_WB(ctrl_w_WB), .alu_out_wb(alu_out_wb),
    .br_en_wb(br_en_wb), .u_imm_wb(u_imm_wb), .mem_data_out_wb(mem_data_out_wb), .pc_wb(pc_wb),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  bit chk_en = 1'b0;

  // model expectations: e_* for the current cycle's combinational outputs, e_wb_* for MEM/WB
  logic        e_memop, e_stall, e_read, e_write, e_store;
  logic [31:0] e_addr, e_wdata;
  logic [3:0]  e_wmask;
  logic        e_wb_valid, e_wb_load, e_wb_ldreg, e_wb_br;
  cw_writeback e_wb_ctrl;
  logic [31:0] e_wb_alu, e_wb_uimm, e_wb_pc, e_wb_mem;
  logic [31:0] e_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] cnt_visible(input logic [31:0] c);
`ifdef MEM_STALL_CNT_EN
    return c;
`else
    return 32'd0 & c;
`endif
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] rd);
    logic [31:0] b, h;
    b = (rd >> (8 * int'(a))) & 32'hFF;
    h = (rd >> (16 * (int'(a) / 2))) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 32'd128)   ? b - 32'd256   : b;
      3'b001:  return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return rd;
    endcase
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] rs2,
                             output logic [3:0] m, output logic [31:0] d);
    int half;
    half = int'(a) / 2;
    case (f3)
      3'b000:  begin m = 4'(1 << int'(a)); d = rs2 << (8 * int'(a)); end
      3'b001:  begin m = 4'(3 << (2 * half)); d = rs2 << (16 * half); end
      default: begin m = 4'hF; d = rs2; end
    endcase
  endtask

  function automatic cw_writeback model_wb_ctrl(input cw_writeback c);
    cw_writeback r;
    r = c;
    if (c.regfilemux_sel inside {RF_LB, RF_LBU, RF_LH, RF_LHU}) r.regfilemux_sel = RF_LW;
    return r;
  endfunction

  task automatic model_reset();
    e_memop = 0; e_stall = 0; e_read = 0; e_write = 0; e_store = 0;
    e_addr = '0; e_wdata = '0; e_wmask = '0;
    e_wb_valid = 0; e_wb_load = 0; e_wb_ldreg = 0; e_wb_br = 0; e_wb_ctrl = '0;
    e_wb_alu = '0; e_wb_uimm = '0; e_wb_pc = '0; e_wb_mem = '0; e_cnt = '0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall_mem", 32'(stall_mem), 32'(e_stall));
      chk("dmem_read", 32'(dmem_read), 32'(e_read));
      chk("dmem_write", 32'(dmem_write), 32'(e_write));
      if (e_memop) chk("dmem_address", dmem_address, e_addr);
      if (e_store) begin
        chk("dmem_wmask", 32'(dmem_wmask), 32'(e_wmask));
        chk("dmem_wdata", dmem_wdata, e_wdata);
      end
      chk("wb_valid", 32'(wb_valid), 32'(e_wb_valid));
      chk("wb_ld_reg", 32'(ctrl_w_WB.ld_reg), 32'(e_wb_ldreg));
      if (e_wb_valid) begin
        chk("ctrl_w_WB", 32'(ctrl_w_WB), 32'(e_wb_ctrl));
        chk("alu_out_wb", alu_out_wb, e_wb_alu);
        chk("br_en_wb", 32'(br_en_wb), 32'(e_wb_br));
        chk("u_imm_wb", u_imm_wb, e_wb_uimm);
        chk("pc_wb", pc_wb, e_wb_pc);
        if (e_wb_load) chk("mem_data_out_wb", mem_data_out_wb, e_wb_mem);
      end
      chk("stall_cycles", stall_cycles, cnt_visible(e_cnt));
    end
  end

  // One instruction held in EX/MEM until it completes; lat = cycles before dmem_resp.
  // Entered and left at posedge+2.
  task automatic run_instr(input bit v, input cw_mem cm, input cw_writeback cw,
                           input logic [31:0] alu, input logic [31:0] rs2, input logic [31:0] rdata,
                           input bit br, input logic [31:0] uimm, input logic [31:0] pc,
                           input int lat, input bit stale);
    bit memop, last;
    int n;
    memop = v && (cm.mem_read || cm.mem_write);
    n = memop ? lat : 0;
    for (int k = 0; k <= n; k++) begin
      last = (k == n);
      ex_valid = v; ctrl_m_MEM = cm; ctrl_w_MEM = cw; alu_out_mem = alu; rs2_mem = rs2;
      br_en_mem = br; u_imm_mem = uimm; pc_mem = pc;
      dmem_resp  = memop ? last : stale;
      dmem_rdata = (memop && last) ? rdata : $urandom;
      e_memop = memop;
      e_stall = memop && !last;
      e_read  = memop && cm.mem_read;
      e_write = memop && !cm.mem_read && cm.mem_write;
      e_store = e_write;
      e_addr  = alu & 32'hFFFF_FFFC;
      model_store(cm.funct3, alu[1:0], rs2, e_wmask, e_wdata);
      @(posedge clk);
      if (e_stall) begin
        e_wb_valid = 0; e_wb_ldreg = 0; e_wb_load = 0;
        e_cnt = e_cnt + 32'd1;
      end else begin
        e_wb_valid = v; e_wb_ldreg = cw.ld_reg; e_wb_ctrl = model_wb_ctrl(cw);
        e_wb_alu = alu; e_wb_br = br; e_wb_uimm = uimm; e_wb_pc = pc;
        e_wb_load = cm.mem_read;
        e_wb_mem = model_load(cm.funct3, alu[1:0], rdata);
      end
      #2;
    end
  endtask

  task automatic clear_inputs();
    ex_valid = 0; ctrl_m_MEM = '0; ctrl_w_MEM = '0; alu_out_mem = '0; rs2_mem = '0;
    br_en_mem = 0; u_imm_mem = '0; pc_mem = '0; dmem_rdata = '0; dmem_resp = 0;
  endtask

  task automatic do_reset();
    chk_en = 0;
    rst = 0;
    clear_inputs();
    model_reset();
    @(posedge clk);
    #2;
    rst = 1;
  endtask

  function automatic cw_mem mk_m(input bit r, input bit w, input logic [2:0] f3);
    cw_mem c;
    c.mem_read = r; c.mem_write = w; c.funct3 = f3;
    return c;
  endfunction

  function automatic cw_writeback mk_w(input regfilemux_sel_t s, input bit ld, input logic [4:0] rd);
    cw_writeback c;
    c.regfilemux_sel = s; c.ld_reg = ld; c.rd_sel = rd;
    return c;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, lat, f3sel;
    bit v, r, w;
    logic [2:0] f3;
    logic [2:0] ld_f3 [5];
    cw_writeback cw;
    ld_f3[0] = 3'b000; ld_f3[1] = 3'b001; ld_f3[2] = 3'b010; ld_f3[3] = 3'b100; ld_f3[4] = 3'b101;

    // reset with a load presented: strobes must stay low and MEM/WB must be clear
    rst = 0;
    clear_inputs();
    model_reset();
    ex_valid = 1; ctrl_m_MEM = mk_m(1, 0, 3'b010);
    #1;
    chk("reset_dmem_read", 32'(dmem_read), 32'd0);
    chk("reset_wb_valid", 32'(wb_valid), 32'd0);
    chk("reset_alu_out_wb", alu_out_wb, 32'd0);
    chk("reset_mem_data_wb", mem_data_out_wb, 32'd0);
    chk("reset_stall_cycles", stall_cycles, 32'd0);
    do_reset();
    chk_en = 1;

    // ALU op passes through in one cycle
    run_instr(1, mk_m(0, 0, 3'b000), mk_w(RF_ALU_OUT, 1, 5'd3), 32'h1234, 32'h0, 32'h0,
              1, 32'h5000, 32'h100, 0, 0);
    chk("alu_direct_out", alu_out_wb, 32'h0000_1234);
    chk("alu_direct_valid", 32'(wb_valid), 32'd1);

    // lb at 0x1003, three stall cycles, sign-extended top byte
    fork
      begin
        int s = 0;
        repeat (4) begin
          @(negedge clk);
          if (stall_mem) s++;
        end
        chk("lb_stall_count", 32'(s), 32'd3);
      end
    join_none
    run_instr(1, mk_m(1, 0, 3'b000), mk_w(RF_LB, 1, 5'd5), 32'h1003, 32'h0, 32'h80AA_BBCC,
              0, 32'h0, 32'h104, 3, 0);
    chk("lb_direct_data", mem_data_out_wb, 32'hFFFF_FF80);
    chk("lb_direct_sel", 32'(ctrl_w_WB.regfilemux_sel), 32'(RF_LW));

    // lhu at 0x2002
    run_instr(1, mk_m(1, 0, 3'b101), mk_w(RF_LHU, 1, 5'd6), 32'h2002, 32'h0, 32'h9876_ABCD,
              0, 32'h0, 32'h108, 1, 0);
    chk("lhu_direct_data", mem_data_out_wb, 32'h0000_9876);

    // sb at 0x3001
    fork
      begin
        @(negedge clk);
        chk("sb_direct_wmask", 32'(dmem_wmask), 32'h2);
        chk("sb_direct_wdata", dmem_wdata, 32'h0000_EE00);
        chk("sb_direct_addr", dmem_address, 32'h0000_3000);
      end
    join_none
    run_instr(1, mk_m(0, 1, 3'b000), mk_w(RF_ALU_OUT, 0, 5'd0), 32'h3001, 32'h0000_00EE, 32'h0,
              0, 32'h0, 32'h10C, 2, 0);

    // randomized stream
    for (int i = 0; i < 250; i++) begin
      kind = $urandom_range(0, 9);
      v = 1; r = 0; w = 0;
      f3 = 3'($urandom_range(0, 7));
      if (kind == 0) begin
        v = 0; r = 1'($urandom_range(0, 1)); w = 1'($urandom_range(0, 1));
      end else if (kind >= 5 && kind <= 7) begin
        r = 1; w = (kind == 7) ? 1'($urandom_range(0, 1)) : 1'b0;
        f3sel = $urandom_range(0, 4);
        f3 = ld_f3[f3sel];
      end else if (kind >= 8) begin
        w = 1; f3 = 3'($urandom_range(0, 2));
      end
      cw = mk_w(regfilemux_sel_t'($urandom_range(0, 8)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
      lat = $urandom_range(0, 5);
      run_instr(v, mk_m(r, w, f3), cw, $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)),
                $urandom, $urandom, lat, 1'($urandom_range(0, 1)));
    end

    // reset in the middle of a WAIT
    chk_en = 0;
    ex_valid = 1; ctrl_m_MEM = mk_m(1, 0, 3'b010); ctrl_w_MEM = mk_w(RF_LW, 1, 5'd7);
    alu_out_mem = 32'h4008; dmem_resp = 0;
    @(posedge clk); #2;
    @(posedge clk); #2;
    chk("wait_read_before_rst", 32'(dmem_read), 32'd1);
    rst = 0;
    #1;
    chk("rst_mid_wait_read", 32'(dmem_read), 32'd0);
    chk("rst_mid_wait_wb_valid", 32'(wb_valid), 32'd0);
    clear_inputs();
    dmem_resp = 1;
    model_reset();
    @(posedge clk); #2;
    rst = 1;
    chk_en = 1;
    run_instr(0, mk_m(0, 0, 3'b000), mk_w(RF_ALU_OUT, 0, 5'd0), 32'h0, 32'h0, 32'h0,
              0, 32'h0, 32'h0, 0, 1);
    run_instr(1, mk_m(1, 0, 3'b010), mk_w(RF_LW, 1, 5'd8), 32'h5004, 32'h0, 32'hCAFE_F00D,
              0, 32'h0, 32'h200, 2, 0);
    chk("post_rst_lw_data", mem_data_out_wb, 32'hCAFE_F00D);
    chk("post_rst_lw_valid", 32'(wb_valid), 32'd1);

    // stall counter: two loads of four stall cycles each from a fresh reset
    do_reset();
    chk_en = 1;
    run_instr(1, mk_m(1, 0, 3'b010), mk_w(RF_LW, 1, 5'd9), 32'h6000, 32'h0, 32'h1111_2222,
              0, 32'h0, 32'h300, 4, 0);
    run_instr(1, mk_m(1, 0, 3'b010), mk_w(RF_LW, 1, 5'd10), 32'h6004, 32'h0, 32'h3333_4444,
              0, 32'h0, 32'h304, 4, 0);
`ifdef MEM_STALL_CNT_EN
    chk("stall_cycles_two_loads", stall_cycles, 32'd8);
`else
    chk("stall_cycles_two_loads", stall_cycles, 32'd0);
`endif

    @(negedge clk);
    chk_en = 0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
